// File: rtl/systolic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | systolic_pkg: shared constants, FSM state type and drain-length helper.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package systolic_pkg;

    localparam int ARRSIZE = 8;
    localparam int DATA_W  = 8;
    localparam int ACC_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Cycles for the last operand to cross the skewed array and land in the
    // far-corner accumulator.
    function automatic int DRAIN_CYC(input int arrsize, input int pe_lat);
        return 2 * (arrsize - 1) + 1 + pe_lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | systolic_ctrl_if: command, operand-read and array-feed bundle.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface systolic_ctrl_if #(
    parameter int ARRSIZE = systolic_pkg::ARRSIZE
);
    import systolic_pkg::*;

    logic                             start;
    logic                             abort;
    logic [7:0]                       k_len;
    logic                             busy;
    logic                             done;
    logic                             rd_en;
    logic [7:0]                       rd_addr;
    logic                             array_clr;
    logic [ARRSIZE-1:0][DATA_W-1:0]   a_col_in;
    logic [ARRSIZE-1:0][DATA_W-1:0]   x_row_in;
    logic [ARRSIZE-1:0][DATA_W-1:0]   row_weights;
    logic [ARRSIZE-1:0][DATA_W-1:0]   col_activations;

    modport master (
        input  start, abort, k_len, a_col_in, x_row_in,
        output busy, done, rd_en, rd_addr, array_clr, row_weights, col_activations
    );

    modport slave (
        output start, abort, k_len, a_col_in, x_row_in,
        input  busy, done, rd_en, rd_addr, array_clr, row_weights, col_activations
    );

endinterface
`default_nettype wire

// File: rtl/skew_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | skew_line: DEPTH-stage delay line with synchronous flush; DEPTH=0 is a wire.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module skew_line #(
    parameter int DEPTH = 0,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = clk ^ rst ^ i_flush;
            assign o_dout   = i_din;
        end else begin : g_dly
            logic [WIDTH-1:0] r_sh [DEPTH];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int n = 0; n < DEPTH; n++) r_sh[n] <= '0;
                end else if (i_flush) begin
                    for (int n = 0; n < DEPTH; n++) r_sh[n] <= '0;
                end else begin
                    r_sh[0] <= i_din;
                    for (int n = 1; n < DEPTH; n++) r_sh[n] <= r_sh[n-1];
                end
            end

            assign o_dout = r_sh[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/systolic_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | systolic_ctrl: sequences one NxN systolic matrix-multiply pass and skews   |
// | the A/X operand streams onto the array edges. Rev 1.0                      |
// +----------------------------------------------------------------------------+
module systolic_ctrl #(
    parameter int ARRSIZE = systolic_pkg::ARRSIZE,
    parameter int PE_LAT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    systolic_ctrl_if.master  bus
);
    import systolic_pkg::*;

    localparam int C_DRAIN  = DRAIN_CYC(ARRSIZE, PE_LAT);
    localparam int C_DCNT_W = $clog2(C_DRAIN + 1);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [7:0]                     r_klen;
    logic [7:0]                     r_addr;
    logic [C_DCNT_W-1:0]            r_dcnt;
    logic                           r_rd_vld;
    logic                           w_busy;
    logic                           w_done;
    logic                           w_rd_en;
    logic                           w_clr;
    logic [ARRSIZE-1:0][DATA_W-1:0] w_a_gated;
    logic [ARRSIZE-1:0][DATA_W-1:0] w_x_gated;
    logic [ARRSIZE-1:0][DATA_W-1:0] w_rows;
    logic [ARRSIZE-1:0][DATA_W-1:0] w_cols;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Abort has priority everywhere, including over start while idle.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_rd_en     = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_nxt = ST_CLEAR;
            ST_CLEAR: begin
                w_busy      = 1'b1;
                w_clr       = 1'b1;
                w_state_nxt = (r_klen == 8'd0) ? ST_DONE : ST_FEED;
            end
            ST_FEED: begin
                w_busy  = 1'b1;
                w_rd_en = 1'b1;
                if (r_addr == r_klen - 8'd1) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (r_dcnt == C_DCNT_W'(C_DRAIN - 1)) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (bus.abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_klen   <= 8'd0;
            r_addr   <= 8'd0;
            r_dcnt   <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) r_klen <= bus.k_len;

            // Address holds at K-1 once the feed finishes, so it never wraps.
            if (bus.abort || r_state == ST_CLEAR)
                r_addr <= 8'd0;
            else if (r_state == ST_FEED && w_state_nxt == ST_FEED)
                r_addr <= r_addr + 8'd1;

            if (r_state == ST_DRAIN) r_dcnt <= r_dcnt + 1'b1;
            else                     r_dcnt <= '0;

            r_rd_vld <= w_rd_en && !bus.abort;
        end
    end

    // Read data is only meaningful in the cycle after a strobe; zero it otherwise.
    always_comb begin
        w_a_gated = '0;
        w_x_gated = '0;
        if (r_rd_vld) begin
            w_a_gated = bus.a_col_in;
            w_x_gated = bus.x_row_in;
        end
    end

    generate
        for (genvar g = 0; g < ARRSIZE; g++) begin : g_lane
            skew_line #(.DEPTH(g), .WIDTH(DATA_W)) u_row (
                .clk     (clk),
                .rst     (rst),
                .i_flush (bus.abort),
                .i_din   (w_a_gated[g]),
                .o_dout  (w_rows[g])
            );
            skew_line #(.DEPTH(g), .WIDTH(DATA_W)) u_col (
                .clk     (clk),
                .rst     (rst),
                .i_flush (bus.abort),
                .i_din   (w_x_gated[g]),
                .o_dout  (w_cols[g])
            );
        end
    endgenerate

    assign bus.busy            = w_busy;
    assign bus.done            = w_done;
    assign bus.rd_en           = w_rd_en;
    assign bus.rd_addr         = r_addr;
    assign bus.array_clr       = w_clr;
    assign bus.row_weights     = w_rows;
    assign bus.col_activations = w_cols;

endmodule
`default_nettype wire
